// File: rtl/mlp_weight_sequencer.sv
// mlp_weight_sequencer
// Sequences one job for mlp_accelerator. It streams the packed weight and bias
// words into the accelerator's load port, then pulses start and waits for done.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cfg_go                start a job (pulse); only honoured in IDLE
//   cfg_skip_load         sampled with cfg_go; reuse resident weights
//   cfg_abort             return to IDLE from any state
//   cfg_checksum          (WSEQ_CHECKSUM_EN only) expected sum of the stream
//   s_data/s_valid/s_ready  weight stream input
//   load_mode/load_addr/load_data/load_valid  accelerator load port
//   acc_start/acc_ready/acc_done              accelerator control
//   busy, done, err, words_loaded             host status
//
// Optional feature: define WSEQ_CHECKSUM_EN to add a wrap-around checksum of
// the accepted stream. A mismatch sets err and cancels the run.
module mlp_weight_sequencer #(
    parameter int IN_WIDTH = 32,
    parameter int POS_DIM  = 63,
    parameter int DIR_DIM  = 27,
    parameter int OUT_DIM  = 4,
    parameter int L1_UNITS = 16,
    parameter int L2_UNITS = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_go,
    input  logic                cfg_skip_load,
    input  logic                cfg_abort,
`ifdef WSEQ_CHECKSUM_EN
    input  logic [IN_WIDTH-1:0] cfg_checksum,
`endif
    input  logic [IN_WIDTH-1:0] s_data,
    input  logic                s_valid,
    output logic                s_ready,
    output logic                load_mode,
    output logic [15:0]         load_addr,
    output logic [IN_WIDTH-1:0] load_data,
    output logic                load_valid,
    output logic                acc_start,
    input  logic                acc_ready,
    input  logic                acc_done,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [15:0]         words_loaded
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] DRAIN = 3'd2;
    localparam logic [2:0] ARM   = 3'd3;
    localparam logic [2:0] RUN   = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    // Last column index of each section (sections 0..5 in load order).
    function automatic logic [8:0] cols_m1(input logic [3:0] sec);
        case (sec)
            4'd0:    cols_m1 = 9'(POS_DIM - 1);
            4'd1:    cols_m1 = 9'(L1_UNITS - 1);
            4'd2:    cols_m1 = 9'(L1_UNITS - 1);
            4'd3:    cols_m1 = 9'(L2_UNITS - 1);
            4'd4:    cols_m1 = 9'(L2_UNITS + DIR_DIM - 1);
            default: cols_m1 = 9'(OUT_DIM - 1);
        endcase
    endfunction

    // Last row index of each section; bias sections have a single row.
    function automatic logic [4:0] rows_m1(input logic [3:0] sec);
        case (sec)
            4'd0:    rows_m1 = 5'(L1_UNITS - 1);
            4'd2:    rows_m1 = 5'(L2_UNITS - 1);
            4'd4:    rows_m1 = 5'(OUT_DIM - 1);
            default: rows_m1 = 5'd0;
        endcase
    endfunction

    logic [2:0] state;
    logic [2:0] state_next;
    logic [3:0] section;
    logic [3:0] row;
    logic [7:0] col;
    logic       handshake;
    logic       last_col;
    logic       last_row;
    logic       last_word;
    logic       go_accept;
    logic       sum_ok;

`ifdef WSEQ_CHECKSUM_EN
    logic [IN_WIDTH-1:0] sum;
    logic [IN_WIDTH-1:0] checksum_q;
    logic                err_q;
    assign sum_ok = (sum == checksum_q);
    assign err    = err_q;
`else
    assign sum_ok = 1'b1;
    assign err    = 1'b0;
`endif

    assign s_ready   = (state == LOAD);
    assign load_mode = (state == LOAD) || (state == DRAIN);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    assign handshake = s_valid && s_ready;
    assign last_col  = ({1'b0, col} == cols_m1(section));
    assign last_row  = ({1'b0, row} == rows_m1(section));
    assign last_word = (section == 4'd5) && last_col && last_row;
    assign go_accept = (state == IDLE) && cfg_go && !cfg_abort;

    // Job state machine; abort overrides every other transition.
    always_comb begin
        state_next = state;
        if (cfg_abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (cfg_go) state_next = cfg_skip_load ? ARM : LOAD;
                LOAD:    if (handshake && last_word) state_next = DRAIN;
                DRAIN:   state_next = sum_ok ? ARM : IDLE;
                ARM:     if (acc_ready) state_next = RUN;
                RUN:     if (acc_done) state_next = DONE;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Datapath: the load port is registered with one cycle of latency. The
    // address counters walk col, then row, then section. A new job clears the
    // counters and status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            section      <= 4'd0;
            row          <= 4'd0;
            col          <= 8'd0;
            load_addr    <= 16'd0;
            load_data    <= '0;
            load_valid   <= 1'b0;
            acc_start    <= 1'b0;
            words_loaded <= 16'd0;
`ifdef WSEQ_CHECKSUM_EN
            sum          <= '0;
            checksum_q   <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            state      <= state_next;
            load_valid <= handshake && !cfg_abort;
            acc_start  <= (state == ARM) && acc_ready && !cfg_abort;

            if (handshake) begin
                load_data <= s_data;
                load_addr <= {section, row, col};
                if (words_loaded != 16'hFFFF) begin
                    words_loaded <= words_loaded + 16'd1;
                end
`ifdef WSEQ_CHECKSUM_EN
                sum <= sum + s_data;
`endif
                if (last_col) begin
                    col <= 8'd0;
                    if (last_row) begin
                        row     <= 4'd0;
                        section <= section + 4'd1;
                    end else begin
                        row <= row + 4'd1;
                    end
                end else begin
                    col <= col + 8'd1;
                end
            end

            if (go_accept) begin
                section      <= 4'd0;
                row          <= 4'd0;
                col          <= 8'd0;
                words_loaded <= 16'd0;
`ifdef WSEQ_CHECKSUM_EN
                sum          <= '0;
                checksum_q   <= cfg_checksum;
                err_q        <= 1'b0;
`endif
            end

`ifdef WSEQ_CHECKSUM_EN
            if ((state == DRAIN) && !cfg_abort && !sum_ok) begin
                err_q <= 1'b1;
            end
`endif
        end
    end

endmodule
